bicubic_seq: RTL and testbench
==============================

BICUBIC_SEQ -- requirements
Module: bicubic_seq

Interface
REQ-001 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port RST, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port START, input, 1, single-cycle job request, honoured only when idle.
REQ-004 SHALL have ports H0, V0, input, 7 each, source window origin (column, row) in the 100x100 image.
REQ-005 SHALL have ports SW, SH, input, 5 each, source window width and height; TW, TH, input, 6 each, target width and height; all sampled at START.
REQ-006 SHALL have port ROM_RD, output, 1, ROM read strobe; ROM_A, output, 14, ROM address = row*100+col.
REQ-007 SHALL have port ROM_Q, input, 8, ROM data, valid the cycle after ROM_RD.
REQ-008 SHALL have port WIN_READY, input, 1, datapath can accept a new 16-tap window.
REQ-009 SHALL have ports TAP_VALID, output, 1; TAP_IDX, output, 4; TAP_DATA, output, 8 (ROM_Q forwarded); FX_NUM, FY_NUM, output, 6 each; FX_DEN, FY_DEN, output, 6 each.
REQ-010 SHALL have ports RES_VALID, input, 1, and RES_DATA, input, 8: one-cycle result pulse from the datapath.
REQ-011 SHALL have ports SRAM_WEN, output, 1; SRAM_A, output, 12; SRAM_D, output, 8: result memory write.
REQ-012 SHALL have ports BUSY, output, 1, and DONE, output, 1.

Function
REQ-013 States: IDLE, FETCH, WAIT_RES, WRITE, ADV, FIN; IDLE->FETCH on START when WIN_READY=1, otherwise wait for WIN_READY.
REQ-014 Target scan: row-major over ty 0..TH-1, tx 0..TW-1; SRAM_A = ty*TW+tx.
REQ-015 X phase by DDA: at tx=0, xi=0 and xn=0; per tx step xn += SW-1, and if xn >= TW-1 then xn -= TW-1 and xi += 1; Y identical with SH, TH, per row.
REQ-016 FX_NUM=xn, FX_DEN=TW-1, FY_NUM=yn, FY_DEN=TH-1, held stable from the first tap until WRITE.
REQ-017 FETCH: 16 ROM_RD cycles back to back; tap k uses dy=k/4-1, dx=k%4-1; column = clamp(xi+dx, 0, SW-1)+H0; row = clamp(yi+dy, 0, SH-1)+V0.
REQ-018 TAP_VALID and TAP_IDX=k SHALL be asserted the cycle after the k-th ROM_RD (16 consecutive pulses).
REQ-019 WAIT_RES is left on RES_VALID; RES_DATA is registered; WRITE asserts SRAM_WEN for exactly one cycle with SRAM_D equal to that value.
REQ-020 A RES_VALID pulse outside WAIT_RES SHALL be ignored.
REQ-021 ADV steps the DDA and enters FETCH when WIN_READY=1 and the window is not the last; after the last pixel it enters FIN.
REQ-022 FIN: DONE=1 and BUSY=0, both held until the next accepted START; START clears DONE in the same cycle as BUSY rises.
REQ-023 START while BUSY=1 SHALL be ignored.
REQ-024 TW=1 (or TH=1): denominator forced to 1, xn=0, xi=0 for all tx (ty).
REQ-025 Upscale only, SW<=TW and SH<=TH; otherwise the job SHALL still finish after TW*TH writes with pixel values unspecified.

Reset
REQ-026 With RST=0 all state goes immediately to IDLE, including mid-job, and all outputs are 0 (ROM_RD, ROM_A, TAP_*, F*, SRAM_*, BUSY, DONE).
REQ-027 After RST is released, DONE SHALL remain 0 until a job completes.

Configuration
REQ-028 Macro BICUBIC_SEQ_SKIP_EN: when defined, a pixel with xn=0 and yn=0 issues one ROM_RD at (xi+H0, yi+V0) and no TAP_VALID, then writes ROM_Q directly (WRITE 2 cycles after issue) without WAIT_RES.
REQ-029 Without BICUBIC_SEQ_SKIP_EN every pixel uses the full 16-tap FETCH/WAIT_RES path.

Verification
REQ-030 Job H0=10, V0=20, SW=SH=4, TW=TH=7 -> first ROM_A=2010 (tap 0 clamped), tap 5 ROM_A=2010, tap 15 ROM_A=2212.
REQ-031 Same job at tx=1, ty=0 -> FX_NUM=3, FX_DEN=6, FY_NUM=0; at tx=2 -> xi=1, FX_NUM=0.
REQ-032 Same job with an immediate RES_VALID echo -> exactly 49 SRAM_WEN pulses, SRAM_A 0..48 in order, then DONE=1 held.
REQ-033 With BICUBIC_SEQ_SKIP_EN defined, pixel (0,0) -> one ROM_RD at address 2010 and SRAM write at address 0 of the returned ROM_Q, with zero TAP_VALID.
REQ-034 WIN_READY held 0 for 20 cycles after START -> no ROM_RD until it rises; START pulsed mid-job -> ignored.
REQ-035 RST asserted during FETCH -> all outputs 0 asynchronously; a new START then runs the job from pixel (0,0).

Source files
------------

// File: rtl/bicubic_seq.sv
// bicubic_seq: sequencer for a bicubic upscaler. Walks the target image in
// row-major order, steps the source phase with a DDA, fetches a 4x4 source
// window from ROM for each target pixel, forwards the taps to an external
// datapath and writes the returned pixel into the result SRAM.
//
// Ports:
//   CLK, RST              clock, asynchronous active-low reset
//   START                 one-cycle job request, honoured only when idle
//   H0, V0                source window origin (column, row) in the 100x100 image
//   SW, SH / TW, TH       source window size / target size, sampled at START
//   ROM_RD, ROM_A, ROM_Q  ROM read strobe, address (row*100+col), data (next cycle)
//   WIN_READY             datapath can accept a new 16-tap window
//   TAP_VALID/IDX/DATA    tap stream toward the datapath (TAP_DATA is ROM_Q)
//   FX_*/FY_*             phase numerator/denominator for the current window
//   RES_VALID, RES_DATA   result pulse from the datapath
//   SRAM_WEN, SRAM_A, SRAM_D  result memory write
//   BUSY, DONE            job status
//
// Optional feature macro: BICUBIC_SEQ_SKIP_EN -- pixels that land exactly on a
// source sample (zero phase in both axes) are copied straight from ROM with a
// single read instead of going through the datapath.
module bicubic_seq (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [6:0]  H0,
  input  logic [6:0]  V0,
  input  logic [4:0]  SW,
  input  logic [4:0]  SH,
  input  logic [5:0]  TW,
  input  logic [5:0]  TH,
  output logic        ROM_RD,
  output logic [13:0] ROM_A,
  input  logic [7:0]  ROM_Q,
  input  logic        WIN_READY,
  output logic        TAP_VALID,
  output logic [3:0]  TAP_IDX,
  output logic [7:0]  TAP_DATA,
  output logic [5:0]  FX_NUM,
  output logic [5:0]  FY_NUM,
  output logic [5:0]  FX_DEN,
  output logic [5:0]  FY_DEN,
  input  logic        RES_VALID,
  input  logic [7:0]  RES_DATA,
  output logic        SRAM_WEN,
  output logic [11:0] SRAM_A,
  output logic [7:0]  SRAM_D,
  output logic        BUSY,
  output logic        DONE
);

  localparam int unsigned CW  = 7;   // image coordinate
  localparam int unsigned SDW = 5;   // source window size
  localparam int unsigned TDW = 6;   // target size / phase
  localparam int unsigned PW  = 8;   // absolute pixel row/col
  localparam int unsigned RAW = 14;  // ROM address
  localparam int unsigned SAW = 12;  // SRAM address
  localparam int unsigned DW  = 8;   // pixel data
  localparam int unsigned KW  = 4;   // tap index
  localparam logic [RAW-1:0] IMG_W    = RAW'(100);
  localparam logic [KW-1:0]  LAST_TAP = KW'(15);

`ifdef BICUBIC_SEQ_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_RES,
    S_WRITE,
    S_ADV,
    S_FIN
  } state_t;

  // Clamp a signed window index into 0..n-1 (n==0 treated as 1).
  function automatic logic [SDW-1:0] clamp_idx(input logic signed [7:0] v,
                                               input logic [SDW-1:0] n);
    logic [SDW-1:0] hi;
    hi = (n == '0) ? '0 : SDW'(n - SDW'(1));
    if (v < 8'sd0)                          return '0;
    else if (v > $signed({3'b000, hi}))     return hi;
    else                                    return v[SDW-1:0];
  endfunction

  function automatic logic [RAW-1:0] pix_addr(input logic [PW-1:0] col,
                                              input logic [PW-1:0] row);
    return RAW'(row) * IMG_W + RAW'(col);
  endfunction

  // Tap k covers dy = k/4-1, dx = k%4-1 around (xi, yi), clamped to the window.
  function automatic logic [RAW-1:0] tap_addr(input logic [TDW-1:0] xi_i,
                                              input logic [TDW-1:0] yi_i,
                                              input logic [KW-1:0]  k_i,
                                              input logic [CW-1:0]  h0_i,
                                              input logic [CW-1:0]  v0_i,
                                              input logic [SDW-1:0] sw_i,
                                              input logic [SDW-1:0] sh_i);
    logic signed [7:0] cx;
    logic signed [7:0] cy;
    cx = $signed({2'b00, xi_i}) + $signed({6'b000000, k_i[1:0]}) - 8'sd1;
    cy = $signed({2'b00, yi_i}) + $signed({6'b000000, k_i[3:2]}) - 8'sd1;
    return pix_addr(PW'(h0_i) + PW'(clamp_idx(cx, sw_i)),
                    PW'(v0_i) + PW'(clamp_idx(cy, sh_i)));
  endfunction

  // Direct sample address used by the zero-phase copy path.
  function automatic logic [RAW-1:0] skip_addr(input logic [TDW-1:0] xi_i,
                                               input logic [TDW-1:0] yi_i,
                                               input logic [CW-1:0]  h0_i,
                                               input logic [CW-1:0]  v0_i);
    return pix_addr(PW'(h0_i) + PW'(xi_i), PW'(v0_i) + PW'(yi_i));
  endfunction

  state_t         state_q;
  logic [CW-1:0]  h0_q, v0_q;
  logic [SDW-1:0] sw_q, sh_q;
  logic [TDW-1:0] tw_q, th_q;
  logic [TDW-1:0] tx_q, ty_q;
  logic [TDW-1:0] xi_q, yi_q;
  logic [TDW-1:0] xn_q, yn_q;
  logic [TDW-1:0] fx_den_q, fy_den_q;
  logic [KW-1:0]  k_q;
  logic [SAW-1:0] pix_q;
  logic           skip_q;
  logic           rom_rd_q;
  logic [RAW-1:0] rom_a_q;
  logic           tap_valid_q;
  logic [KW-1:0]  tap_idx_q;
  logic           sram_wen_q;
  logic [SAW-1:0] sram_a_q;
  logic [DW-1:0]  sram_d_q;
  logic           busy_q;
  logic           done_q;

  logic [TDW-1:0] tw_m1_c, th_m1_c;
  logic [SDW-1:0] sw_m1_c, sh_m1_c;
  logic [TDW:0]   xsum_c, ysum_c;
  logic [TDW-1:0] xn_nx_c, xi_nx_c, yn_nx_c, yi_nx_c;
  logic           x_last_c, y_last_c;
  logic           adv_skip_c;
  logic [TDW-1:0] fx_den_start_c, fy_den_start_c;

  // DDA step for the next target pixel; a size of 1 pins the phase at 0.
  always_comb begin
    tw_m1_c    = (tw_q == '0) ? '0 : TDW'(tw_q - TDW'(1));
    th_m1_c    = (th_q == '0) ? '0 : TDW'(th_q - TDW'(1));
    sw_m1_c    = (sw_q == '0) ? '0 : SDW'(sw_q - SDW'(1));
    sh_m1_c    = (sh_q == '0) ? '0 : SDW'(sh_q - SDW'(1));
    x_last_c   = (tx_q >= tw_m1_c);
    y_last_c   = (ty_q >= th_m1_c);
    xsum_c     = (TDW+1)'(xn_q) + (TDW+1)'(sw_m1_c);
    ysum_c     = (TDW+1)'(yn_q) + (TDW+1)'(sh_m1_c);
    xn_nx_c    = TDW'(xsum_c);
    xi_nx_c    = xi_q;
    yn_nx_c    = TDW'(ysum_c);
    yi_nx_c    = yi_q;
    if (tw_q <= TDW'(1)) begin
      xn_nx_c = '0;
      xi_nx_c = '0;
    end else if (xsum_c >= (TDW+1)'(tw_m1_c)) begin
      xn_nx_c = TDW'(xsum_c - (TDW+1)'(tw_m1_c));
      xi_nx_c = TDW'(xi_q + TDW'(1));
    end
    if (th_q <= TDW'(1)) begin
      yn_nx_c = '0;
      yi_nx_c = '0;
    end else if (ysum_c >= (TDW+1)'(th_m1_c)) begin
      yn_nx_c = TDW'(ysum_c - (TDW+1)'(th_m1_c));
      yi_nx_c = TDW'(yi_q + TDW'(1));
    end
    adv_skip_c     = SKIP_EN && (xn_q == '0) && (yn_q == '0);
    fx_den_start_c = (TW <= TDW'(1)) ? TDW'(1) : TDW'(TW - TDW'(1));
    fy_den_start_c = (TH <= TDW'(1)) ? TDW'(1) : TDW'(TH - TDW'(1));
  end

  // Sequencer state and all registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      h0_q        <= '0;
      v0_q        <= '0;
      sw_q        <= '0;
      sh_q        <= '0;
      tw_q        <= '0;
      th_q        <= '0;
      tx_q        <= '0;
      ty_q        <= '0;
      xi_q        <= '0;
      yi_q        <= '0;
      xn_q        <= '0;
      yn_q        <= '0;
      fx_den_q    <= '0;
      fy_den_q    <= '0;
      k_q         <= '0;
      pix_q       <= '0;
      skip_q      <= 1'b0;
      rom_rd_q    <= 1'b0;
      rom_a_q     <= '0;
      tap_valid_q <= 1'b0;
      tap_idx_q   <= '0;
      sram_wen_q  <= 1'b0;
      sram_a_q    <= '0;
      sram_d_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // Taps appear one cycle after their read, matching ROM latency.
      tap_valid_q <= rom_rd_q && !skip_q;
      tap_idx_q   <= (rom_rd_q && !skip_q) ? k_q : '0;
      sram_wen_q  <= 1'b0;

      unique case (state_q)
        S_IDLE, S_FIN: begin
          if (START) begin
            h0_q     <= H0;
            v0_q     <= V0;
            sw_q     <= SW;
            sh_q     <= SH;
            tw_q     <= TW;
            th_q     <= TH;
            fx_den_q <= fx_den_start_c;
            fy_den_q <= fy_den_start_c;
            tx_q     <= '0;
            ty_q     <= '0;
            xi_q     <= '0;
            yi_q     <= '0;
            xn_q     <= '0;
            yn_q     <= '0;
            pix_q    <= '0;
            k_q      <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            if (WIN_READY) begin
              state_q  <= S_FETCH;
              rom_rd_q <= 1'b1;
              skip_q   <= SKIP_EN;
              rom_a_q  <= SKIP_EN ? skip_addr('0, '0, H0, V0)
                                  : tap_addr('0, '0, '0, H0, V0, SW, SH);
            end else begin
              state_q <= S_ADV;
            end
          end
        end

        S_FETCH: begin
          if (skip_q) begin
            // Read issued last cycle; ROM_Q is the pixel itself.
            if (k_q == '0) begin
              rom_rd_q <= 1'b0;
              k_q      <= KW'(1);
            end else begin
              k_q        <= '0;
              sram_wen_q <= 1'b1;
              sram_a_q   <= pix_q;
              sram_d_q   <= ROM_Q;
              state_q    <= S_WRITE;
            end
          end else if (k_q == LAST_TAP) begin
            rom_rd_q <= 1'b0;
            k_q      <= '0;
            state_q  <= S_WAIT_RES;
          end else begin
            k_q     <= KW'(k_q + KW'(1));
            rom_a_q <= tap_addr(xi_q, yi_q, KW'(k_q + KW'(1)), h0_q, v0_q, sw_q, sh_q);
          end
        end

        S_WAIT_RES: begin
          if (RES_VALID) begin
            sram_wen_q <= 1'b1;
            sram_a_q   <= pix_q;
            sram_d_q   <= RES_DATA;
            state_q    <= S_WRITE;
          end
        end

        S_WRITE: begin
          if (x_last_c && y_last_c) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else begin
            pix_q   <= SAW'(pix_q + SAW'(1));
            state_q <= S_ADV;
            if (x_last_c) begin
              tx_q <= '0;
              xi_q <= '0;
              xn_q <= '0;
              ty_q <= TDW'(ty_q + TDW'(1));
              yi_q <= yi_nx_c;
              yn_q <= yn_nx_c;
            end else begin
              tx_q <= TDW'(tx_q + TDW'(1));
              xi_q <= xi_nx_c;
              xn_q <= xn_nx_c;
            end
          end
        end

        S_ADV: begin
          if (WIN_READY) begin
            state_q  <= S_FETCH;
            rom_rd_q <= 1'b1;
            k_q      <= '0;
            skip_q   <= adv_skip_c;
            rom_a_q  <= adv_skip_c ? skip_addr(xi_q, yi_q, h0_q, v0_q)
                                   : tap_addr(xi_q, yi_q, '0, h0_q, v0_q, sw_q, sh_q);
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ROM_RD    = rom_rd_q;
  assign ROM_A     = rom_a_q;
  assign TAP_VALID = tap_valid_q;
  assign TAP_IDX   = tap_idx_q;
  // ROM data is forwarded in the cycle it is valid; gated so it idles at 0.
  assign TAP_DATA  = tap_valid_q ? ROM_Q : '0;
  assign FX_NUM    = xn_q;
  assign FY_NUM    = yn_q;
  assign FX_DEN    = fx_den_q;
  assign FY_DEN    = fy_den_q;
  assign SRAM_WEN  = sram_wen_q;
  assign SRAM_A    = sram_a_q;
  assign SRAM_D    = sram_d_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_bicubic_seq.sv
// Scoreboard bench for bicubic_seq: expected ROM addresses, phases and SRAM
// writes are queued per job; a negedge monitor pops and compares them.
module tb_bicubic_seq;

  logic        CLK, RST, START, WIN_READY, RES_VALID;
  logic [6:0]  H0, V0;
  logic [4:0]  SW, SH;
  logic [5:0]  TW, TH;
  logic        ROM_RD, TAP_VALID, SRAM_WEN, BUSY, DONE;
  logic [13:0] ROM_A;
  logic [7:0]  ROM_Q, TAP_DATA, RES_DATA, SRAM_D;
  logic [3:0]  TAP_IDX;
  logic [5:0]  FX_NUM, FY_NUM, FX_DEN, FY_DEN;
  logic [11:0] SRAM_A;

  bicubic_seq dut (
    .CLK(CLK), .RST(RST), .START(START), .H0(H0), .V0(V0),
    .SW(SW), .SH(SH), .TW(TW), .TH(TH),
    .ROM_RD(ROM_RD), .ROM_A(ROM_A), .ROM_Q(ROM_Q), .WIN_READY(WIN_READY),
    .TAP_VALID(TAP_VALID), .TAP_IDX(TAP_IDX), .TAP_DATA(TAP_DATA),
    .FX_NUM(FX_NUM), .FY_NUM(FY_NUM), .FX_DEN(FX_DEN), .FY_DEN(FY_DEN),
    .RES_VALID(RES_VALID), .RES_DATA(RES_DATA),
    .SRAM_WEN(SRAM_WEN), .SRAM_A(SRAM_A), .SRAM_D(SRAM_D),
    .BUSY(BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [11:0] a;
    logic [7:0]  d;
    bit          care;
  } wr_t;

  logic [13:0] q_rom[$];
  logic [23:0] q_frac[$];
  wr_t         q_wr[$];

  int n_chk = 0;
  int n_pass = 0;
  bit rom_chk = 1'b1;
  bit frac_chk = 1'b1;
  bit spur_en = 1'b0;
  int rd_cnt, wr_cnt, tap_total, taps_before_wr;
  logic [3:0]  tap_cnt;
  logic [13:0] rd_log[64];
  logic [23:0] frac_log[64];
  logic [7:0]  wr_d0;
  logic [7:0]  acc;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] rom_f(input logic [13:0] a);
    return a[7:0] ^ {a[13:8], 2'b01};
  endfunction

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic [79:0] outs();
    return 80'({ROM_RD, ROM_A, TAP_VALID, TAP_IDX, TAP_DATA, FX_NUM, FY_NUM,
                FX_DEN, FY_DEN, SRAM_WEN, SRAM_A, SRAM_D, BUSY, DONE});
  endfunction

  // Reference job walk: row-major scan, DDA phase, clamped 4x4 windows.
  task automatic gen_job(input int h0, input int v0, input int sw, input int sh,
                         input int tw, input int th, input bit care);
    int xi, xn, yi, yn, dxd, dyd, col, row, a, sum, p;
    bit skip;
    wr_t e;
    dxd = (tw <= 1) ? 1 : tw - 1;
    dyd = (th <= 1) ? 1 : th - 1;
    yi = 0; yn = 0; p = 0;
    for (int ty = 0; ty < th; ty++) begin
      xi = 0; xn = 0;
      for (int tx = 0; tx < tw; tx++) begin
        skip = 1'b0;
`ifdef BICUBIC_SEQ_SKIP_EN
        skip = (xn == 0) && (yn == 0);
`endif
        if (skip) begin
          a = (yi + v0) * 100 + (xi + h0);
          if (care) q_rom.push_back(14'(a));
          sum = int'(rom_f(14'(a)));
        end else begin
          sum = 0;
          for (int k = 0; k < 16; k++) begin
            col = clampi(xi + k % 4 - 1, sw - 1) + h0;
            row = clampi(yi + k / 4 - 1, sh - 1) + v0;
            a = row * 100 + col;
            if (care) q_rom.push_back(14'(a));
            sum += int'(rom_f(14'(a)));
          end
          if (care) q_frac.push_back({6'(xn), 6'(dxd), 6'(yn), 6'(dyd)});
        end
        e.a = 12'(p); e.d = 8'(sum); e.care = care;
        q_wr.push_back(e);
        p++;
        if (tw > 1) begin
          xn += sw - 1;
          if (xn >= tw - 1) begin xn -= tw - 1; xi++; end
        end
      end
      if (th > 1) begin
        yn += sh - 1;
        if (yn >= th - 1) begin yn -= th - 1; yi++; end
      end
    end
  endtask

  // ROM model: one-cycle read latency.
  always @(posedge CLK) if (ROM_RD) ROM_Q <= rom_f(ROM_A);

  // Datapath model: sums the 16 taps and echoes immediately; optional stray pulse mid-fetch.
  initial begin
    RES_VALID = 1'b0; RES_DATA = 8'h00; acc = 8'h00;
    forever begin
      @(negedge CLK);
      RES_VALID = 1'b0;
      if (RST && TAP_VALID) begin
        acc = (TAP_IDX == 4'd0) ? TAP_DATA : 8'(acc + TAP_DATA);
        if (TAP_IDX == 4'd15) begin
          RES_VALID = 1'b1; RES_DATA = acc;
        end else if (spur_en && TAP_IDX == 4'd7) begin
          RES_VALID = 1'b1; RES_DATA = 8'hA5;
        end
      end
    end
  end

  // Monitor: pops expected values as the DUT presents reads, taps and writes.
  initial begin
    wr_t e;
    logic [13:0] ea;
    logic [23:0] ef;
    forever begin
      @(negedge CLK);
      if (RST) begin
        if (ROM_RD) begin
          if (rom_chk) begin
            chk("rom_q_nonempty", 80'(q_rom.size() != 0), 80'(1));
            if (q_rom.size() != 0) begin
              ea = q_rom.pop_front();
              chk("rom_addr", 80'(ROM_A), 80'(ea));
            end
          end
          if (rd_cnt < 64) rd_log[rd_cnt] = ROM_A;
          rd_cnt++;
        end
        if (TAP_VALID) begin
          chk("tap_idx", 80'(TAP_IDX), 80'(tap_cnt));
          tap_cnt = 4'(tap_cnt + 4'd1);
          tap_total++;
          if (wr_cnt == 0) taps_before_wr++;
          if (TAP_IDX == 4'd0) begin
            if (wr_cnt < 64) frac_log[wr_cnt] = {FX_NUM, FX_DEN, FY_NUM, FY_DEN};
            if (frac_chk) begin
              chk("frac_q_nonempty", 80'(q_frac.size() != 0), 80'(1));
              if (q_frac.size() != 0) begin
                ef = q_frac.pop_front();
                chk("frac", 80'({FX_NUM, FX_DEN, FY_NUM, FY_DEN}), 80'(ef));
              end
            end
          end
        end
        if (SRAM_WEN) begin
          chk("wr_q_nonempty", 80'(q_wr.size() != 0), 80'(1));
          if (q_wr.size() != 0) begin
            e = q_wr.pop_front();
            chk("sram_a", 80'(SRAM_A), 80'(e.a));
            if (e.care) chk("sram_d", 80'(SRAM_D), 80'(e.d));
          end
          if (wr_cnt == 0) wr_d0 = SRAM_D;
          wr_cnt++;
        end
      end
    end
  end

  task automatic reset_logs();
    rd_cnt = 0; wr_cnt = 0; tap_total = 0; taps_before_wr = 0; tap_cnt = 4'd0;
  endtask

  task automatic start_job(input int h0, input int v0, input int sw, input int sh,
                           input int tw, input int th);
    @(negedge CLK);
    H0 = 7'(h0); V0 = 7'(v0); SW = 5'(sw); SH = 5'(sh); TW = 6'(tw); TH = 6'(th);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !DONE; i++) @(negedge CLK);
    chk("done_timeout", 80'(DONE), 80'(1));
  endtask

  task automatic check_drained(input int n_wr);
    chk("wr_count", 80'(wr_cnt), 80'(n_wr));
    chk("wr_q_empty", 80'(q_wr.size()), 80'(0));
    if (rom_chk) chk("rom_q_empty", 80'(q_rom.size()), 80'(0));
    if (frac_chk) chk("frac_q_empty", 80'(q_frac.size()), 80'(0));
  endtask

  initial begin
    RST = 1'b0; START = 1'b0; WIN_READY = 1'b1;
    H0 = '0; V0 = '0; SW = '0; SH = '0; TW = '0; TH = '0;
    reset_logs();
    repeat (3) @(negedge CLK);
    chk("reset_outs", outs(), 80'(0));
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("idle_outs", outs(), 80'(0));
    chk("done_after_reset", 80'(DONE), 80'(0));

    // Job A: 4x4 -> 7x7 with a stray result pulse during every fetch.
    reset_logs(); spur_en = 1'b1;
    gen_job(10, 20, 4, 4, 7, 7, 1'b1);
    start_job(10, 20, 4, 4, 7, 7);
    chk("start_busy", 80'({BUSY, DONE}), 80'(2'b10));
    wait_done(3000);
    spur_en = 1'b0;
    check_drained(49);
`ifdef BICUBIC_SEQ_SKIP_EN
    chk("skip_addr0", 80'(rd_log[0]), 80'(14'd2010));
    chk("skip_data0", 80'(wr_d0), 80'(rom_f(14'd2010)));
    chk("skip_no_taps", 80'(taps_before_wr), 80'(0));
`else
    chk("tap0_addr", 80'(rd_log[0]), 80'(14'd2010));
    chk("tap5_addr", 80'(rd_log[5]), 80'(14'd2010));
    chk("tap15_addr", 80'(rd_log[15]), 80'(14'd2212));
    chk("frac_tx1", 80'(frac_log[1]), 80'({6'd3, 6'd6, 6'd0, 6'd6}));
    chk("frac_tx2", 80'(frac_log[2]), 80'({6'd0, 6'd6, 6'd0, 6'd6}));
    chk("tx2_xi1_addr", 80'(rd_log[37]), 80'(14'd2011));
    chk("tap_total", 80'(tap_total), 80'(49 * 16));
`endif
    repeat (5) @(negedge CLK);
    chk("done_held", 80'({BUSY, DONE}), 80'(2'b01));

    // Job B: window not ready for 20 cycles, then a START pulse mid-job.
    reset_logs(); WIN_READY = 1'b0;
    gen_job(50, 60, 3, 2, 5, 4, 1'b1);
    start_job(50, 60, 3, 2, 5, 4);
    chk("restart_clears_done", 80'({BUSY, DONE}), 80'(2'b10));
    repeat (19) @(negedge CLK);
    chk("no_rd_until_ready", 80'(rd_cnt), 80'(0));
    WIN_READY = 1'b1;
    for (int i = 0; i < 2000 && wr_cnt < 3; i++) @(negedge CLK);
    chk("mid_job_reached", 80'(wr_cnt >= 3), 80'(1));
    start_job(0, 0, 1, 1, 9, 9);
    chk("busy_start_ignored", 80'(BUSY), 80'(1));
    wait_done(3000);
    check_drained(20);

    // Job C: single-column target, window at the image corner.
    reset_logs();
    gen_job(99, 99, 1, 2, 1, 3, 1'b1);
    start_job(99, 99, 1, 2, 1, 3);
    wait_done(1000);
    check_drained(3);

    // Job D: downscale still finishes after TW*TH writes.
    reset_logs(); rom_chk = 1'b0; frac_chk = 1'b0;
    gen_job(5, 5, 8, 5, 3, 2, 1'b0);
    start_job(5, 5, 8, 5, 3, 2);
    wait_done(1000);
    check_drained(6);
    rom_chk = 1'b1; frac_chk = 1'b1;

    // Job E: reset during fetch, then a fresh job starts from pixel 0.
    reset_logs();
    gen_job(10, 20, 4, 4, 7, 7, 1'b1);
    start_job(10, 20, 4, 4, 7, 7);
    for (int i = 0; i < 500 && rd_cnt < 20; i++) @(negedge CLK);
    chk("fetch_reached", 80'(rd_cnt >= 20), 80'(1));
    #2 RST = 1'b0;
    #1 chk("async_reset_outs", outs(), 80'(0));
    q_rom.delete(); q_frac.delete(); q_wr.delete();
    @(negedge CLK);
    RST = 1'b1;
    reset_logs();
    gen_job(30, 40, 2, 2, 2, 2, 1'b1);
    start_job(30, 40, 2, 2, 2, 2);
    wait_done(1000);
    check_drained(4);
    chk("rerun_first_addr", 80'(rd_log[0]), 80'(14'd4030));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
